// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, their response ports, the single RAM port
// and the arbitration enable shared between the arbiter and its environment.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  arb_en;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_dout, arb_en,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output ram_we, ram_addr, ram_din
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_dout, arb_en,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one synchronous RAM port, with
// a registered issue stage and a two-stage read tag pipeline for response routing.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  ram_port_arbiter_if.slave bus
);

  logic                  ptr_reg, ptr_next;
  logic                  grant_id;
  logic                  accept;
  logic [1:0]            valid_vec;
  logic [1:0]            ready_vec;
  logic [1:0]            rsp_valid_vec;

  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  logic                  ram_we_reg, ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_WIDTH-1:0] ram_din_reg, ram_din_next;

  logic                  tag1_valid_reg, tag1_valid_next;
  logic                  tag1_id_reg, tag1_id_next;
  logic                  tag2_valid_reg, tag2_valid_next;
  logic                  tag2_id_reg, tag2_id_next;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

  always_comb begin
    accept   = bus.arb_en && (valid_vec != 2'b00);
    // The pointer only matters under contention; a lone requester always wins.
    grant_id = (valid_vec == 2'b11) ? ptr_reg : valid_vec[1];

    win_we    = grant_id ? bus.req1_we    : bus.req0_we;
    win_addr  = grant_id ? bus.req1_addr  : bus.req0_addr;
    win_wdata = grant_id ? bus.req1_wdata : bus.req0_wdata;

    ptr_next      = accept ? ~grant_id : ptr_reg;
    ram_we_next   = accept && win_we;
    ram_addr_next = accept ? win_addr  : ram_addr_reg;
    ram_din_next  = accept ? win_wdata : ram_din_reg;

    tag1_valid_next = accept && !win_we;
    tag1_id_next    = grant_id;
    tag2_valid_next = tag1_valid_reg;
    tag2_id_next    = tag1_id_reg;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi]     = accept && (grant_id == 1'(gi));
      assign rsp_valid_vec[gi] = tag2_valid_reg && (tag2_id_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_din_reg    <= '0;
      tag1_valid_reg <= 1'b0;
      tag1_id_reg    <= 1'b0;
      tag2_valid_reg <= 1'b0;
      tag2_id_reg    <= 1'b0;
    end else begin
      ptr_reg        <= ptr_next;
      ram_we_reg     <= ram_we_next;
      ram_addr_reg   <= ram_addr_next;
      ram_din_reg    <= ram_din_next;
      tag1_valid_reg <= tag1_valid_next;
      tag1_id_reg    <= tag1_id_next;
      tag2_valid_reg <= tag2_valid_next;
      tag2_id_reg    <= tag2_id_next;
    end
  end

  assign bus.req0_ready = ready_vec[0];
  assign bus.req1_ready = ready_vec[1];
  assign bus.ram_we     = ram_we_reg;
  assign bus.ram_addr   = ram_addr_reg;
  assign bus.ram_din    = ram_din_reg;
  // Read data is forced to zero outside the owner's response cycle.
  assign bus.rsp0_valid = rsp_valid_vec[0];
  assign bus.rsp1_valid = rsp_valid_vec[1];
  assign bus.rsp0_rdata = rsp_valid_vec[0] ? bus.ram_dout : '0;
  assign bus.rsp1_rdata = rsp_valid_vec[1] ? bus.ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a RAM model drives ram_dout, an acceptance-order
// reference model is compared every cycle, and directed scenarios pin literals.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with registered read (read-before-write)
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory updated in acceptance order, responses due 2 cycles later
  typedef struct {
    int          due;
    logic        owner;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic          m_ptr;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  // Logs of what the DUT actually did, used for literal checks
  int            g_log[$];
  int            a_cyc[$];
  int            r_owner[$];
  int            r_data[$];
  int            r_cyc[$];

  logic          e_v0, e_v1, e_r0, e_r1, acc, win, w_we;
  logic [DW-1:0] e_d0, e_d1, w_data;
  logic [AW-1:0] w_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_din", bus.ram_din, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_rsp0_rdata", bus.rsp0_rdata, 0);
      chk("rst_rsp1_rdata", bus.rsp1_rdata, 0);
      m_ptr = 1'b0;
      exp_q.delete();
      e_we = 1'b0; e_addr = '0; e_din = '0;
    end else begin
      chk("ram_we", bus.ram_we, e_we);
      chk("ram_addr", bus.ram_addr, e_addr);
      chk("ram_din", bus.ram_din, e_din);

      e_v0 = 0; e_v1 = 0; e_d0 = '0; e_d1 = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due == cyc) begin
          if (exp_q[i].owner) begin e_v1 = 1; e_d1 = exp_q[i].data; end
          else                begin e_v0 = 1; e_d0 = exp_q[i].data; end
          exp_q.delete(i);
        end
      end
      chk("rsp0_valid", bus.rsp0_valid, e_v0);
      chk("rsp1_valid", bus.rsp1_valid, e_v1);
      chk("rsp0_rdata", bus.rsp0_rdata, e_d0);
      chk("rsp1_rdata", bus.rsp1_rdata, e_d1);
      if (bus.rsp0_valid) begin r_owner.push_back(0); r_data.push_back(bus.rsp0_rdata); r_cyc.push_back(cyc); end
      if (bus.rsp1_valid) begin r_owner.push_back(1); r_data.push_back(bus.rsp1_rdata); r_cyc.push_back(cyc); end
      if (bus.rsp0_valid || bus.rsp1_valid)
        $display("rsp  cyc=%0d owner=%0d data=%02h", cyc, bus.rsp1_valid, bus.ram_dout);

      acc = bus.arb_en && (bus.req0_valid || bus.req1_valid);
      win = (bus.req0_valid && bus.req1_valid) ? m_ptr : bus.req1_valid;
      e_r0 = acc && !win;
      e_r1 = acc && win;
      chk("req0_ready", bus.req0_ready, e_r0);
      chk("req1_ready", bus.req1_ready, e_r1);
      if (bus.req0_ready || bus.req1_ready) begin
        g_log.push_back(bus.req1_ready ? 1 : 0);
        if ((bus.req0_ready && !bus.req0_we) || (bus.req1_ready && !bus.req1_we))
          a_cyc.push_back(cyc);
      end

      if (acc) begin
        w_we   = win ? bus.req1_we    : bus.req0_we;
        w_addr = win ? bus.req1_addr  : bus.req0_addr;
        w_data = win ? bus.req1_wdata : bus.req0_wdata;
        $display("acc  cyc=%0d req=%0d we=%0d addr=%02h wdata=%02h", cyc, win, w_we, w_addr, w_data);
        m_ptr  = ~win;
        e_we   = w_we;
        e_addr = w_addr;
        e_din  = w_data;
        if (w_we) m_mem[w_addr] = w_data;
        else exp_q.push_back('{due: cyc + 2, owner: win, data: m_mem[w_addr]});
      end else begin
        e_we = 1'b0;
      end
    end
  end

  task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
  endtask
  task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
  endtask
  task automatic idle();
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    g_log.delete(); a_cyc.delete(); r_owner.delete(); r_data.delete(); r_cyc.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    rst_n = 1'b0;
    bus.arb_en = 1'b1;
    idle();
    tick(2);
    rst_n = 1'b1;

    // Single requester write then read-back
    clear_logs();
    set0(1, 1, 8'h10, 8'h55); tick(1);
    set0(1, 0, 8'h10, 8'h00); tick(1);
    idle(); tick(4);
    chk("t1_grants", g_log.size(), 2);
    chk("t1_rsp_count", r_owner.size(), 1);
    chk("t1_rsp_owner", r_owner[0], 0);
    chk("t1_rsp_data", r_data[0], 8'h55);
    chk("t1_latency", r_cyc[0] - a_cyc[0], 2);

    // Preload, reset, then contention from the first edge after release
    set0(1, 1, 8'h01, 8'h11); tick(1);
    set0(1, 1, 8'h02, 8'h22); tick(1);
    idle(); tick(1);
    rst_n = 1'b0; tick(2);
    clear_logs();
    rst_n = 1'b1;
    set0(1, 0, 8'h01, 8'h00);
    set1(1, 0, 8'h02, 8'h00);
    tick(4);
    idle(); tick(4);
    chk("t2_grants", g_log.size(), 4);
    chk("t2_grant0", g_log[0], 0);
    chk("t2_grant1", g_log[1], 1);
    chk("t2_grant2", g_log[2], 0);
    chk("t2_grant3", g_log[3], 1);
    chk("t2_rsp1_owner", r_owner[1], 1);
    chk("t2_rsp1_data", r_data[1], 8'h22);
    chk("t2_rsp2_data", r_data[2], 8'h11);

    // Back-to-back writes and reads from requester 1
    clear_logs();
    set1(1, 1, 8'h20, 8'hAA); tick(1);
    set1(1, 1, 8'h21, 8'hBB); tick(1);
    set1(1, 0, 8'h20, 8'h00); tick(1);
    set1(1, 0, 8'h21, 8'h00); tick(1);
    idle(); tick(4);
    chk("t3_grants", g_log.size(), 4);
    chk("t3_rsp0_data", r_data[0], 8'hAA);
    chk("t3_rsp1_data", r_data[1], 8'hBB);
    chk("t3_rsp_owner", r_owner[0], 1);
    chk("t3_rsp_spacing", r_cyc[1] - r_cyc[0], 1);

    // Write from requester 0 seen by a read from requester 1 next cycle
    clear_logs();
    set0(1, 1, 8'h30, 8'hCC); tick(1);
    set0(0, 0, 8'h00, 8'h00);
    set1(1, 0, 8'h30, 8'h00); tick(1);
    idle(); tick(4);
    chk("t4_rsp_owner", r_owner[0], 1);
    chk("t4_rsp_data", r_data[0], 8'hCC);

    // Disable arbitration while a read is still in flight
    clear_logs();
    set0(1, 0, 8'h10, 8'h00); tick(1);
    set0(1, 0, 8'h11, 8'h00);
    set1(1, 0, 8'h12, 8'h00);
    bus.arb_en = 1'b0;
    #1;
    chk("t5_ready0", bus.req0_ready, 0);
    chk("t5_ready1", bus.req1_ready, 0);
    tick(2);
    idle(); bus.arb_en = 1'b1; tick(4);
    chk("t5_grants", g_log.size(), 1);
    chk("t5_rsp_count", r_owner.size(), 1);
    chk("t5_rsp_data", r_data[0], 8'h55);

    // Reset right after a read acceptance discards the response
    clear_logs();
    set0(1, 0, 8'h10, 8'h00); tick(1);
    idle();
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(4);
    chk("t6_no_rsp", r_owner.size(), 0);
    clear_logs();
    set0(1, 0, 8'h01, 8'h00);
    set1(1, 0, 8'h02, 8'h00);
    tick(2);
    idle(); tick(4);
    chk("t6_first_grant", g_log[0], 0);
    chk("t6_rsp_count", r_owner.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 The module SHALL have a single clock and an asynchronous, active-low reset: clk  input  1  clock, all state on rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-004 The module SHALL have per-requester ports, N in {0,1}: reqN_valid  input  1  request present; reqN_ready  output  1  request accepted this cycle; reqN_we  input  1  1=write, 0=read; reqN_addr  input  ADDR_WIDTH  address; reqN_wdata  input  DATA_WIDTH  write data.
REQ-005 The module SHALL have per-requester response ports: rspN_valid  output  1  read data valid; rspN_rdata  output  DATA_WIDTH  read data.
REQ-006 The module SHALL have RAM-side ports for one synchronous RAM port: ram_we  output  1; ram_addr  output  ADDR_WIDTH; ram_din  output  DATA_WIDTH; ram_dout  input  DATA_WIDTH, registered RAM output valid one edge after address sampled.
REQ-007 The module SHALL have arb_en  input  1; 0 = grant nothing, in-flight operations complete.

Function
REQ-008 Acceptance SHALL occur when reqN_valid && reqN_ready at a rising edge; at most one requester accepted per cycle.
REQ-009 reqN_ready SHALL be combinational: high only for the granted requester, only when arb_en=1 and reqN_valid=1.
REQ-010 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the winner when both are valid; a lone valid requester always wins.
REQ-011 After an acceptance from requester N, the pointer SHALL favour the other requester; the pointer SHALL be unchanged on cycles with no acceptance.
REQ-012 Issue stage: on acceptance at edge T, ram_we/ram_addr/ram_din SHALL be registered from the winner at T; the RAM samples them at edge T+1.
REQ-013 On cycles with no acceptance, ram_we SHALL register 0 at the next edge; ram_addr and ram_din SHALL hold their previous values.
REQ-014 For an accepted read, the module SHALL track requester ID through a 2-stage tag pipeline: stage 1 = issued at T, stage 2 = RAM data available after T+1.
REQ-015 rspN_valid SHALL be high for exactly one cycle, the cycle following edge T+1, for the owning requester only; read latency is 2 cycles from acceptance.
REQ-016 rspN_rdata SHALL equal ram_dout whenever rspN_valid=1; it SHALL be 0 when rspN_valid=0.
REQ-017 Writes SHALL produce no response.
REQ-018 Back-to-back acceptances SHALL be sustained at one per cycle, with responses in acceptance order; throughput is 1 op/cycle.
REQ-019 A read to an address written by an earlier accepted write SHALL return the new data, since operations are issued to the single RAM port in acceptance order.
REQ-020 Deasserting arb_en SHALL block new grants from the next combinational evaluation, while pending issue and tag stages drain normally.
REQ-021 Address and data SHALL pass through unmodified; there is no width conversion.

Reset
REQ-022 While rst_n=0, the following SHALL hold: ram_we=0, ram_addr=0, ram_din=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0, pointer favours requester 0, tag pipeline empty.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight reads, and no response SHALL be produced for them after release.
REQ-024 Outputs SHALL change asynchronously on rst_n falling; the first acceptance SHALL be possible at the first rising edge with rst_n=1.

Verification
REQ-025 Single requester: req0 write addr 0x10 data 0x55, then req0 read 0x10 -> ram_we pulse with 0x10/0x55; rsp0_valid exactly 2 cycles after read acceptance, rsp0_rdata=0x55; rsp1_valid stays 0.
REQ-026 Contention after reset: both valid every cycle, reads to 0x01 (req0) and 0x02 (req1) -> grants alternate 0,1,0,1; each requester gets 50%; responses return to the correct owner in order.
REQ-027 Pipelining: req1 writes 0x20=0xAA then 0x21=0xBB, then reads 0x20 and 0x21 on consecutive cycles -> four accepts in four cycles; rsp1_rdata = 0xAA then 0xBB on consecutive cycles.
REQ-028 Ordering: req0 write 0x30=0xCC accepted, req1 read 0x30 accepted the next cycle -> rsp1_rdata=0xCC.
REQ-029 arb_en: drop arb_en with both valid -> ready0=ready1=0; ram_we=0 after one edge; pending read still responds.
REQ-030 Reset: assert rst_n=0 one cycle after a read acceptance -> no rsp_valid after release; all outputs 0; next contention grants requester 0 first.
